// File: rtl/tsu_queue_mc.sv
// Multi-channel timestamp capture unit: per-channel holding registers, round-robin
// arbitration into one shared FWFT queue drained by a valid/ack handshake.
module tsu_queue_mc #(
  parameter int N_CH  = 2,
  parameter int TS_W  = 80,
  parameter int TAG_W = 20,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = AW + 1
) (
  input  logic                  rtc_timer_clk,
  input  logic                  rst_n,
  input  logic [TS_W-1:0]       rtc_timer_in,
  input  logic [N_CH-1:0]       cap_stb,
  input  logic [N_CH*TAG_W-1:0] cap_tag,
  input  logic [N_CH-1:0]       cap_en,
  output logic                  ts_valid,
  input  logic                  ts_ack,
  output logic [CH_W-1:0]       ts_chan,
  output logic [TS_W-1:0]       ts_data,
  output logic [TAG_W-1:0]      ts_tag,
  output logic [LVL_W-1:0]      q_level,
  output logic [CNT_W-1:0]      ovf_cnt,
  input  logic                  ovf_clr
);

  localparam int OVF_MAX = (1 << CNT_W) - 1;

  logic [N_CH-1:0]  pending;
  logic [TS_W-1:0]  hold_ts  [N_CH];
  logic [TAG_W-1:0] hold_tag [N_CH];
  logic [CH_W-1:0]  rr_ptr;

  logic [TS_W-1:0]  mem_ts  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [CH_W-1:0]  mem_ch  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  logic             grant_found;
  logic [CH_W-1:0]  grant_idx;
  logic             full, pop, wr_en;
  logic [N_CH-1:0]  accept, drained, drop;
  logic [CNT_W-1:0] ovf_nxt;

  // Round-robin search: descending offsets so the nearest pending channel after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = N_CH; off >= 1; off--) begin
      if (pending[(int'(rr_ptr) + off) % N_CH]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'((int'(rr_ptr) + off) % N_CH);
      end
    end
  end

  assign ts_valid = (q_level != '0);
  assign full     = (q_level == LVL_W'(DEPTH));
  assign pop      = ts_valid & ts_ack;
  // A full queue still accepts a write when the head leaves on the same edge.
  assign wr_en    = grant_found & (~full | pop);

  always_comb begin
    int sum;
    accept  = cap_stb & cap_en;
    drained = '0;
    if (wr_en) drained[grant_idx] = 1'b1;
    drop    = accept & pending & ~drained;
    sum     = ovf_clr ? 0 : int'(ovf_cnt);
    for (int i = 0; i < N_CH; i++) sum += int'(drop[i]);
    ovf_nxt = (sum > OVF_MAX) ? CNT_W'(OVF_MAX) : CNT_W'(sum);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge rtc_timer_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      rr_ptr  <= CH_W'(N_CH - 1);
      ovf_cnt <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_ts[i]  <= '0;
        hold_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (accept[i] && !drop[i]) begin
          hold_ts[i]  <= rtc_timer_in;
          hold_tag[i] <= cap_tag[i*TAG_W +: TAG_W];
          pending[i]  <= 1'b1;
        end else if (drained[i]) begin
          pending[i]  <= 1'b0;
        end
      end
      if (wr_en) rr_ptr <= grant_idx;
      ovf_cnt <= ovf_nxt;
    end
  end

  always_ff @(posedge rtc_timer_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      q_level <= q_level + 1'b1;
      else if (pop && !wr_en) q_level <= q_level - 1'b1;
    end
  end

  // NOTE: queue storage has no reset; ts_valid gates every read so stale contents never leak out.
  always_ff @(posedge rtc_timer_clk) begin
    if (wr_en) begin
      mem_ts[wr_ptr]  <= hold_ts[grant_idx];
      mem_tag[wr_ptr] <= hold_tag[grant_idx];
      mem_ch[wr_ptr]  <= grant_idx;
    end
  end

  assign ts_data = ts_valid ? mem_ts[rd_ptr]  : '0;
  assign ts_tag  = ts_valid ? mem_tag[rd_ptr] : '0;
  assign ts_chan = ts_valid ? mem_ch[rd_ptr]  : '0;

endmodule

// File: tb/tb_tsu_queue_mc.sv
// Directed self-checking bench for tsu_queue_mc with default parameters
// (N_CH=2, TS_W=80, TAG_W=20, DEPTH=16, CNT_W=8).
module tb_tsu_queue_mc;

  logic        rtc_timer_clk = 1'b0;
  logic        rst_n;
  logic [79:0] rtc_timer_in;
  logic [1:0]  cap_stb;
  logic [39:0] cap_tag;
  logic [1:0]  cap_en;
  logic        ts_valid;
  logic        ts_ack;
  logic [0:0]  ts_chan;
  logic [79:0] ts_data;
  logic [19:0] ts_tag;
  logic [4:0]  q_level;
  logic [7:0]  ovf_cnt;
  logic        ovf_clr;

  int n_checks = 0;
  int n_pass   = 0;

  tsu_queue_mc dut (
    .rtc_timer_clk(rtc_timer_clk),
    .rst_n        (rst_n),
    .rtc_timer_in (rtc_timer_in),
    .cap_stb      (cap_stb),
    .cap_tag      (cap_tag),
    .cap_en       (cap_en),
    .ts_valid     (ts_valid),
    .ts_ack       (ts_ack),
    .ts_chan      (ts_chan),
    .ts_data      (ts_data),
    .ts_tag       (ts_tag),
    .q_level      (q_level),
    .ovf_cnt      (ovf_cnt),
    .ovf_clr      (ovf_clr)
  );

  always #5 rtc_timer_clk = ~rtc_timer_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge rtc_timer_clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] m, input logic [79:0] ts,
                        input logic [19:0] t0, input logic [19:0] t1);
    rtc_timer_in = ts;
    cap_tag      = {t1, t0};
    cap_stb      = m;
    tick();
    cap_stb      = 2'b00;
  endtask

  task automatic ack();
    ts_ack = 1'b1;
    tick();
    ts_ack = 1'b0;
  endtask

  task automatic head(input string tag, input logic ch, input logic [79:0] ts, input logic [19:0] tg);
    check({tag, "_valid"}, ts_valid, 1'b1);
    check({tag, "_chan"},  ts_chan,  ch);
    check({tag, "_data"},  ts_data,  ts);
    check({tag, "_tag"},   ts_tag,   tg);
  endtask

  initial begin
    rst_n = 1'b0; rtc_timer_in = '0; cap_stb = '0; cap_tag = '0;
    cap_en = 2'b11; ts_ack = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check("rst_valid", ts_valid, 1'b0);
    check("rst_level", q_level, 5'd0);
    check("rst_ovf",   ovf_cnt, 8'd0);
    check("rst_data",  ts_data, 80'd0);
    rst_n = 1'b1;
    tick();

    // Single strobe: visible after the second edge.
    strobe(2'b01, 80'h64, 20'h10005, 20'h0);
    check("single_lat_valid", ts_valid, 1'b0);
    tick();
    head("single", 1'b0, 80'h64, 20'h10005);
    check("single_level", q_level, 5'd1);
    ack();
    check("single_pop_level", q_level, 5'd0);
    check("single_pop_data",  ts_data, 80'd0);
    check("single_pop_tag",   ts_tag,  20'd0);
    check("single_pop_valid", ts_valid, 1'b0);
    ack();
    check("ack_empty_level", q_level, 5'd0);

    // Disabled channel ignored; disabling after capture does not cancel.
    cap_en = 2'b01;
    strobe(2'b10, 80'h70, 20'h0, 20'h7);
    tick();
    check("en_off_level", q_level, 5'd0);
    cap_en = 2'b11;
    strobe(2'b10, 80'h71, 20'h0, 20'h8);
    cap_en = 2'b00;
    tick();
    cap_en = 2'b11;
    head("en_drop", 1'b1, 80'h71, 20'h8);
    ack();

    // Simultaneous strobes: ch0 first, then ch1, same timestamp.
    strobe(2'b11, 80'h200, 20'h1111, 20'h2222);
    tick();
    check("sim_level1", q_level, 5'd1);
    head("sim_first", 1'b0, 80'h200, 20'h1111);
    tick();
    check("sim_level2", q_level, 5'd2);
    ack();
    head("sim_second", 1'b1, 80'h200, 20'h2222);
    ack();
    check("sim_empty", q_level, 5'd0);

    // After a ch0 write, the next simultaneous burst grants ch1 first.
    strobe(2'b01, 80'h300, 20'hA, 20'h0);
    tick();
    strobe(2'b11, 80'h400, 20'hB, 20'hC);
    tick();
    tick();
    check("rr_level", q_level, 5'd3);
    head("rr_a", 1'b0, 80'h300, 20'hA);
    ack();
    head("rr_b", 1'b1, 80'h400, 20'hC);
    ack();
    head("rr_c", 1'b0, 80'h400, 20'hB);
    ack();

    // Re-strobe ch1 the cycle after: drain and accept on the same edge.
    strobe(2'b10, 80'h500, 20'h0, 20'h51);
    strobe(2'b10, 80'h501, 20'h0, 20'h52);
    tick();
    check("restb_ovf",   ovf_cnt, 8'd0);
    check("restb_level", q_level, 5'd2);
    head("restb_a", 1'b1, 80'h500, 20'h51);
    ack();
    head("restb_b", 1'b1, 80'h501, 20'h52);
    ack();

    // Fill: 17 strobes, 16 queued, one held.
    for (int i = 0; i <= 16; i++)
      strobe((i % 2) ? 2'b10 : 2'b01, 80'h1000 + 80'(i), 20'(i), 20'(i));
    tick();
    check("full_level", q_level, 5'd16);
    check("full_ovf0",  ovf_cnt, 8'd0);
    strobe(2'b01, 80'h2000, 20'h99, 20'h0);
    check("full_drop_ovf", ovf_cnt, 8'd1);
    strobe(2'b10, 80'h3000, 20'h0, 20'h333);
    check("full_ch1_held_ovf", ovf_cnt, 8'd1);

    // Saturation and clear-with-drop.
    cap_stb = 2'b11;
    for (int i = 0; i < 127; i++) tick();
    cap_stb = 2'b00;
    check("sat_255", ovf_cnt, 8'd255);
    cap_stb = 2'b11;
    tick();
    cap_stb = 2'b00;
    check("sat_hold", ovf_cnt, 8'd255);
    cap_stb = 2'b01; ovf_clr = 1'b1;
    tick();
    cap_stb = 2'b00; ovf_clr = 1'b0;
    check("clr_drop", ovf_cnt, 8'd1);

    // Pop while full lets a held record in on the same edge.
    head("full_head0", 1'b0, 80'h1000, 20'h0);
    ack();
    check("full_swap_level", q_level, 5'd16);
    head("full_head1", 1'b1, 80'h1001, 20'h1);
    ack();
    check("full_swap2_level", q_level, 5'd16);
    for (int i = 0; i < 14; i++) ack();
    head("held_ch0", 1'b0, 80'h1010, 20'h10);
    ack();
    head("held_ch1", 1'b1, 80'h3000, 20'h333);
    ack();
    check("drain_level", q_level, 5'd0);
    check("drain_ovf",   ovf_cnt, 8'd1);

    // Reset mid-burst.
    for (int i = 0; i <= 5; i++)
      strobe((i % 2) ? 2'b10 : 2'b01, 80'h4000 + 80'(i), 20'(i), 20'(i));
    check("pre_rst_level", q_level, 5'd5);
    rst_n = 1'b0;
    #1;
    check("arst_valid", ts_valid, 1'b0);
    check("arst_level", q_level, 5'd0);
    check("arst_data",  ts_data, 80'd0);
    check("arst_tag",   ts_tag,  20'd0);
    check("arst_chan",  ts_chan, 1'b0);
    check("arst_ovf",   ovf_cnt, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_level", q_level, 5'd0);
    strobe(2'b11, 80'h5000, 20'h55, 20'h66);
    tick();
    head("post_rst_first", 1'b0, 80'h5000, 20'h55);
    tick();
    check("post_rst_level2", q_level, 5'd2);
    ack();
    head("post_rst_second", 1'b1, 80'h5000, 20'h66);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
